// File: rtl/uart_xmit_if.sv
// Host-side port bundle for the buffered UART transmitter.
// trmt is a one-cycle valid strobe with no ready: fifo_full is the inverted ready,
// and a strobe seen while fifo_full is high is discarded without any effect.
interface uart_xmit_if;
    logic       trmt;
    logic [7:0] tx_data;
    logic       TX;
    logic       tx_done;
    logic       fifo_full;
    logic       busy;

    modport master (
        output trmt, tx_data,
        input  TX, tx_done, fifo_full, busy
    );

    modport slave (
        input  trmt, tx_data,
        output TX, tx_done, fifo_full, busy
    );
endinterface

// File: rtl/uart_xmit.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/8 data/stop serializer.
// Frames leave LSB first, each bit held BAUD_DIV clocks, with one idle clock between queued frames.
module uart_xmit #(
    parameter int BAUD_DIV   = 2604,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_xmit_if.slave  bus,
    output logic        dbg_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XMIT = 1'b1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;

    logic [0:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift_reg;
    logic          tx_done_q;

    // The extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push       = bus.trmt && !fifo_full;
    assign pop        = (state == IDLE) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= bus.tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '1;
            tx_done_q <= 1'b0;
        end else if (state == IDLE) begin
            if (!fifo_empty) begin
                shift_reg <= {1'b1, mem[rptr[AW-1:0]], 1'b0};
                tx_done_q <= 1'b0;
                baud_cnt  <= '0;
                bit_cnt   <= '0;
                state     <= XMIT;
            end
        end else begin
            if (baud_cnt == BAUD_LAST) begin
                baud_cnt  <= '0;
                shift_reg <= {1'b1, shift_reg[9:1]};
                bit_cnt   <= bit_cnt + 4'd1;
                // Shifting out the stop bit ends the frame on this same edge.
                if (bit_cnt == 4'd9) begin
                    tx_done_q <= 1'b1;
                    state     <= IDLE;
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

    assign bus.TX        = shift_reg[0];
    assign bus.tx_done   = tx_done_q;
    assign bus.fifo_full = fifo_full;
    assign bus.busy      = (state == XMIT) || !fifo_empty;
    assign dbg_state     = state;
endmodule

// File: doc/uart_xmit.md
# uart_xmit

Buffered 8N1 UART transmitter, the transmit-side counterpart of `uart_rcv`. It accepts bytes from the host on a single-cycle `trmt` strobe into a small FIFO. It serializes each byte onto `TX` as start bit, 8 data bits LSB first, then stop bit, at a fixed clocks-per-bit rate matching the receiver. Frames go out back-to-back while the FIFO holds data, and `tx_done` flags completion of the most recent frame.

## Interface
- `BAUD_DIV`, default 2604: clocks per bit period; legal range ≥ 4.
- `FIFO_DEPTH`, default 4: byte entries; power of two, ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `trmt`  in  1  one-cycle push strobe for `tx_data`.
- `tx_data`  in  8  byte to enqueue; sampled only when `trmt`=1.
- `TX`  out  1  serial line; idles high.
- `tx_done`  out  1  high after a frame's stop bit completes; cleared when the next frame starts.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `busy`  out  1  high when a frame is in flight or the FIFO is non-empty.

## Operation
- Reset values:
  - `TX`=1, `tx_done`=0, `fifo_full`=0, `busy`=0.
  - FIFO empty; state IDLE; `baud_cnt`=0; `bit_cnt`=0; 10-bit shift register all ones.
- FIFO:
  - Circular buffer with log2(`FIFO_DEPTH`)+1-bit read/write pointers; the extra MSB distinguishes full from empty.
  - Push when `trmt`=1 and `fifo_full`=0.
  - `trmt` while full is dropped silently: no pointer change, no overwrite.
  - `fifo_full` is computed from registered pointers. A push in the same cycle as a pop while full is still dropped.
  - Push and pop in the same cycle when not full: both occur, and the count is unchanged.
- State machine (2 states):
  - IDLE:
    - `TX`=1.
    - If the FIFO is non-empty: load the shift register with {1'b1, head byte, 1'b0}, pop the FIFO, clear `tx_done`, clear `baud_cnt` and `bit_cnt`, and go to XMIT.
    - Otherwise stay in IDLE.
  - XMIT:
    - `baud_cnt` increments each clock.
    - When `baud_cnt`==`BAUD_DIV`-1: reset `baud_cnt` to 0, shift the register right filling with 1, and increment `bit_cnt`.
    - When `bit_cnt` reaches 10 (stop bit finished): set `tx_done` and go to IDLE.
- `TX` is the registered LSB of the shift register, so the output is glitch-free.
- `busy` = (state==XMIT) | FIFO non-empty.
- `tx_data` may change freely except in the cycle `trmt` is high.

## Timing
- Push on edge N: the FIFO is non-empty in cycle N+1.
  - IDLE loads on edge N+1, and `TX` falls after edge N+1.
  - Latency from `trmt` to the start-bit edge is 2 clocks.
- Each bit is held exactly `BAUD_DIV` clocks; a frame lasts 10×`BAUD_DIV` clocks.
- `tx_done` rises on the same edge that ends the stop bit and returns to IDLE.
- Back-to-back frames:
  - Exactly one IDLE clock (`TX`=1) separates the end of one stop bit from the next start bit, giving a stop bit of effective length `BAUD_DIV`+1.
  - `tx_done` is high for only that 1 clock between queued frames.
- `tx_done` stays high indefinitely when the FIFO is empty at frame end.
- Asserting `rst_n` low mid-frame aborts immediately: `TX`=1 and the FIFO is flushed. No partial frame resumes after reset.

## Test plan
- Single byte, `BAUD_DIV`=16, push 0xA5 at cycle 10:
  - `TX` falls after cycle 11.
  - Bit values per 16-clock period: 0,1,0,1,0,0,1,0,1,1.
  - `tx_done`=1 from cycle 171.
  - `busy` drops the same edge.
- Fill and overflow, `BAUD_DIV`=16, `FIFO_DEPTH`=4:
  - Push 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 on consecutive clocks.
  - 0x11 is popped first.
  - `fifo_full` asserts after the fifth push (0x55). The sixth push (0x66) is dropped.
  - Exactly 0x11..0x55 appear on `TX` in order, each separated by one idle clock.
- Push while full in the same cycle as a pop:
  - The pushed byte is dropped.
  - The FIFO count decreases by one.
  - The next frame is the expected older byte.
- Reset mid-frame: assert `rst_n`=0 during data bit 3 of 0xF0 with 2 bytes queued.
  - `TX`=1 immediately, with `busy`=0 and `tx_done`=0.
  - After release, `TX` stays high with no pushes.
- Loopback with `uart_rcv`, default `BAUD_DIV`=2604:
  - Push 0x55 then 0xC3, clearing `rx_rdy` between frames.
  - `uart_rcv` reports `rx_data`=0x55 then 0xC3, with `rx_rdy` set after each frame.
- Idle gap: push 0x00 with `BAUD_DIV`=16, wait until `tx_done`, then push 0xFF.
  - `tx_done` clears when 0xFF's start bit begins.
  - The 0xFF frame is start 0, eight 1s, stop 1.
